// File: rtl/lc2k_instr_encoder_if.sv
// Instruction-field stream and instruction-memory write bus for the LC2K encoder.
interface lc2k_instr_encoder_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_opcode;
    logic [2:0]        in_reg_a;
    logic [2:0]        in_reg_b;
    logic [2:0]        in_dest;
    logic [31:0]       in_offset;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;

    // Encoder side
    modport slave (
        input  in_valid, in_opcode, in_reg_a, in_reg_b, in_dest, in_offset, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    // Instruction source / memory side
    modport master (
        output in_valid, in_opcode, in_reg_a, in_reg_b, in_dest, in_offset, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lc2k_instr_encoder.sv
// LC2K instruction encoder: packs instruction fields into 32-bit words and
// writes them to consecutive instruction-memory addresses until halt.
module lc2k_instr_encoder #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                abort,
    lc2k_instr_encoder_if.slave bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W-1:0]   word_count
);

    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WRITE  = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NOR  = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_JALR = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    state_t              state, state_next;

    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [WORD_W-1:0]   enc_word;
    logic                uses_offset;
    logic                range_fault;
    logic                xfer;
    logic                ack_ok;
    logic                word_is_halt;
    logic                addr_last;

    // Field packing for the incoming instruction
    always_comb begin
        enc_word = {7'b0, bus.in_opcode, bus.in_reg_a, bus.in_reg_b, 16'b0};
        case (bus.in_opcode)
            OP_ADD, OP_NOR:       enc_word[2:0]  = bus.in_dest;
            OP_LW, OP_SW, OP_BEQ: enc_word[15:0] = bus.in_offset[15:0];
            OP_JALR:              enc_word[15:0] = 16'b0;
            default:              enc_word[21:0] = 22'b0;
        endcase
    end

    // Offset must be representable as a 16-bit signed value
    assign uses_offset  = (bus.in_opcode == OP_LW) || (bus.in_opcode == OP_SW) ||
                          (bus.in_opcode == OP_BEQ);
    assign range_fault  = uses_offset && !((&bus.in_offset[31:15]) || !(|bus.in_offset[31:15]));
    assign xfer         = (state == S_ACCEPT) && bus.in_valid && !abort;
    assign ack_ok       = (state == S_WRITE) && bus.mem_ack && !abort;
    assign word_is_halt = (wdata_q[24:22] == OP_HALT);
    assign addr_last    = &addr_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state_next = S_ACCEPT;
                S_ACCEPT: if (bus.in_valid) state_next = range_fault ? S_ERROR : S_WRITE;
                S_WRITE: begin
                    if (bus.mem_ack) begin
                        if (word_is_halt)   state_next = S_DONE;
                        else if (addr_last) state_next = S_ERROR;
                        else                state_next = S_ACCEPT;
                    end
                end
                S_DONE:   state_next = S_IDLE;
                S_ERROR:  state_next = S_IDLE;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // Next values for the datapath and registered outputs
    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        err_d   = err_q;
        ready_d = (state_next == S_ACCEPT);
        busy_d  = (state_next != S_IDLE);
        done_d  = (state_next == S_DONE);
        if (abort) begin
            we_d = 1'b0;
        end else begin
            if ((state == S_IDLE) && start) begin
                addr_d  = base_addr;
                count_d = '0;
                err_d   = 1'b0;
            end
            if (xfer) begin
                if (range_fault) begin
                    err_d = 1'b1;
                end else begin
                    wdata_d = enc_word;
                    we_d    = 1'b1;
                end
            end
            if (ack_ok) begin
                we_d    = 1'b0;
                addr_d  = addr_q + ADDR_W'(1);
                count_d = count_q + ADDR_W'(1);
                if (!word_is_halt && addr_last) err_d = 1'b1;
            end
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = err_q;
    assign word_count    = count_q;

endmodule

// File: tb/tb_lc2k_instr_encoder.sv
// Self-checking bench for lc2k_instr_encoder: directed scenarios plus
// randomized program loads checked against an arithmetic encoding model.
module tb_lc2k_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic        abort;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    int n_checks = 0;
    int n_pass   = 0;

    lc2k_instr_encoder_if #(.ADDR_W(16)) bus ();

    lc2k_instr_encoder #(.ADDR_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference encoding built from the field layout with plain arithmetic
    function automatic logic [31:0] ref_word(input int op, input int a, input int b,
                                             input int d, input int off);
        int low;
        if (op == 6 || op == 7) return 32'(op * 4194304);
        case (op)
            0, 1:    low = d;
            2, 3, 4: low = (off < 0) ? off + 65536 : off;
            default: low = 0;
        endcase
        return 32'(op * 4194304 + a * 524288 + b * 65536 + low);
    endfunction

    function automatic bit ref_fault(input int op, input int off);
        return (op >= 2 && op <= 4) && (off < -32768 || off > 32767);
    endfunction

    task automatic do_start(input int base);
        start     = 1'b1;
        base_addr = 16'(base);
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input int op, input int a, input int b, input int d, input int off);
        int waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) check("ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_opcode = 3'(op);
        bus.in_reg_a  = 3'(a);
        bus.in_reg_b  = 3'(b);
        bus.in_dest   = 3'(d);
        bus.in_offset = 32'(off);
        tick();
        bus.in_valid  = 1'b0;
    endtask

    // Expect a write of ed at ea, hold ack low for dly cycles, then acknowledge
    task automatic expect_write(input int dly, input int ea, input logic [31:0] ed);
        check("we_after_xfer", 32'(bus.mem_we), 32'd1);
        check("wr_addr", 32'(bus.mem_addr), 32'(ea));
        check("wr_data", bus.mem_wdata, ed);
        for (int i = 0; i < dly; i++) begin
            tick();
            check("hold_we", 32'(bus.mem_we), 32'd1);
            check("hold_addr", 32'(bus.mem_addr), 32'(ea));
            check("hold_data", bus.mem_wdata, ed);
            check("hold_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("we_after_ack", 32'(bus.mem_we), 32'd0);
    endtask

    function automatic int rand_offset(input int op);
        int sel;
        int bnd[4] = '{-32769, -32768, 32767, 32768};
        if (op < 2 || op > 4) return int'($urandom);
        sel = int'($urandom_range(0, 7));
        if (sel < 2) return bnd[$urandom_range(0, 3)];
        if (sel == 2) return ($urandom_range(0, 1) != 0) ? 32768 + int'($urandom_range(0, 100000))
                                                         : -32769 - int'($urandom_range(0, 100000));
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic random_load();
        int  base, ea, n, op, a, b, d, off, cnt;
        bit  ended;
        base  = ($urandom_range(0, 3) == 0) ? 65535 - int'($urandom_range(0, 3))
                                            : int'($urandom_range(0, 65535));
        do_start(base);
        ea    = base;
        cnt   = 0;
        ended = 1'b0;
        n     = int'($urandom_range(1, 6));
        for (int i = 0; i < n && !ended; i++) begin
            op  = (i == n - 1) ? 6 : int'($urandom_range(0, 7));
            a   = int'($urandom_range(0, 7));
            b   = int'($urandom_range(0, 7));
            d   = int'($urandom_range(0, 7));
            off = rand_offset(op);
            send(op, a, b, d, off);
            if (ref_fault(op, off)) begin
                check("rnd_fault_we", 32'(bus.mem_we), 32'd0);
                check("rnd_fault_err", 32'(error), 32'd1);
                ended = 1'b1;
            end else begin
                expect_write(int'($urandom_range(0, 3)), ea, ref_word(op, a, b, d, off));
                cnt++;
                check("rnd_count", 32'(word_count), 32'(cnt));
                if (op == 6) begin
                    check("rnd_done", 32'(done), 32'd1);
                    check("rnd_err_clear", 32'(error), 32'd0);
                    ended = 1'b1;
                end else if (ea == 65535) begin
                    check("rnd_wrap_err", 32'(error), 32'd1);
                    ended = 1'b1;
                end else begin
                    check("rnd_ready", 32'(bus.in_ready), 32'd1);
                    ea++;
                end
            end
        end
        tick();
        check("rnd_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int pulses;
        rst_n         = 1'b0;
        start         = 1'b0;
        base_addr     = '0;
        abort         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_reg_a  = '0;
        bus.in_reg_b  = '0;
        bus.in_dest   = '0;
        bus.in_offset = '0;
        bus.mem_ack   = 1'b0;
        #12;
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // add, then lw with negative offset, then halt in one load
        do_start(16'h0010);
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(bus.in_ready), 32'd1);
        send(0, 1, 2, 3, 0);
        expect_write(0, 16'h0010, 32'h000A0003);
        check("add_count", 32'(word_count), 32'd1);
        send(2, 0, 1, 5, -1);
        expect_write(0, 16'h0011, 32'h0081FFFF);
        send(6, 7, 7, 7, 0);
        expect_write(0, 16'h0012, 32'h01800000);
        pulses = int'(done);
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(done);
        end
        check("done_pulses", 32'(pulses), 32'd1);
        check("halt_idle", 32'(busy), 32'd0);

        // sw offset out of range
        do_start(16'h0100);
        send(3, 1, 1, 0, 40000);
        check("sw_fault_we", 32'(bus.mem_we), 32'd0);
        check("sw_fault_err", 32'(error), 32'd1);
        check("sw_fault_state", 32'(busy), 32'd1);
        tick();
        check("sw_fault_idle", 32'(busy), 32'd0);
        check("sw_err_sticky", 32'(error), 32'd0 + 32'd1);

        // delayed ack, and start ignored while busy
        do_start(16'h0200);
        check("err_cleared", 32'(error), 32'd0);
        start     = 1'b1;
        base_addr = 16'h0300;
        tick();
        start     = 1'b0;
        send(1, 4, 5, 6, 0);
        expect_write(5, 16'h0200, ref_word(1, 4, 5, 6, 0));
        send(7, 1, 2, 3, 0);
        expect_write(1, 16'h0201, 32'h01C00000);

        // abort together with ack in WRITE
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", 32'(busy), 32'd0);
        do_start(16'h0400);
        send(5, 2, 3, 0, 0);
        abort       = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        abort       = 1'b0;
        bus.mem_ack = 1'b0;
        check("abort_we", 32'(bus.mem_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_count", 32'(word_count), 32'd0);
        check("abort_err", 32'(error), 32'd0);

        // address wrap at all-ones
        do_start(16'hFFFF);
        send(7, 0, 0, 0, 0);
        expect_write(0, 16'hFFFF, 32'h01C00000);
        check("wrap_err", 32'(error), 32'd1);
        check("wrap_count", 32'(word_count), 32'd1);
        tick();
        check("wrap_idle", 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(bus.mem_we);
        end
        check("wrap_no_write", 32'(pulses), 32'd0);

        // reset during WRITE
        do_start(16'h0500);
        send(0, 1, 1, 1, 0);
        check("pre_rst_we", 32'(bus.mem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_we", 32'(bus.mem_we), 32'd0);
        check("async_rst_count", 32'(word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        for (int k = 0; k < 40; k++) random_load();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lc2k_instr_encoder.md
LC2K_INSTR_ENCODER -- requirements
Module: lc2k_instr_encoder

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-002 Parameter ADDR_W, default 16: width of the instruction-memory address.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle pulse that begins a program load; honoured only in IDLE.
REQ-006 base_addr  input  ADDR_W  first write address, sampled on the accepted start.
REQ-007 abort  input  1  ends the load and returns to IDLE; no error is raised.
REQ-008 in_valid  input  1  instruction fields below are valid.
REQ-009 in_ready  output  1  encoder can accept the fields this cycle.
REQ-010 in_opcode  input  3  0 add, 1 nor, 2 lw, 3 sw, 4 beq, 5 jalr, 6 halt, 7 noop.
REQ-011 in_reg_a, in_reg_b, in_dest  input  3 each  register fields.
REQ-012 in_offset  input  32  signed offset, two's complement.
REQ-013 mem_we  output  1  write request to instruction memory.
REQ-014 mem_addr  output  ADDR_W  write address.
REQ-015 mem_wdata  output  32  encoded instruction word.
REQ-016 mem_ack  input  1  memory accepted the write; may be delayed any number of cycles.
REQ-017 busy  output  1  high whenever the state is not IDLE.
REQ-018 done  output  1  one-cycle pulse after the halt word is written.
REQ-019 error  output  1  sticky flag; cleared by the next accepted start or by reset.
REQ-020 word_count  output  ADDR_W  number of words written in the current load.

Function
REQ-021 The state machine has five states: IDLE, ACCEPT, WRITE, DONE, ERROR.
REQ-022 IDLE transitions to ACCEPT on start; on that edge it loads the address register from base_addr and clears word_count and error.
REQ-023 in_ready is high only in ACCEPT; a transfer occurs on a rising edge where in_valid and in_ready are both high.
REQ-024 Bits 31-25 of the encoded word are 0, bits 24-22 are the opcode, bits 21-19 are regA, and bits 18-16 are regB.
REQ-025 add and nor place dest in bits 2-0 and set bits 15-3 to 0.
REQ-026 lw, sw and beq place in_offset[15:0] in bits 15-0.
REQ-027 jalr sets bits 15-0 to 0.
REQ-028 halt and noop set bits 21-0 to 0; register inputs are ignored.
REQ-029 For lw, sw and beq, an in_offset outside -32768..32767 is a range fault.
REQ-030 On a range fault the transfer is consumed, nothing is written, error is set, and the state goes to ERROR.
REQ-031 A legal transfer registers the word into mem_wdata and goes to WRITE; mem_we is asserted the cycle after the transfer (latency 1).
REQ-032 In WRITE, mem_we, mem_addr and mem_wdata are held stable until the edge on which mem_ack is sampled high.
REQ-033 On the edge where mem_ack is sampled, the address register and word_count both increment by 1.
REQ-034 After that edge, a halt word sends the state to DONE; any other word sends it back to ACCEPT.
REQ-035 mem_ack seen outside WRITE is ignored.
REQ-036 If a non-halt word is written at address all-ones, the address would wrap; this sets error and the state goes to ERROR.
REQ-037 DONE asserts done for one cycle, then goes to IDLE.
REQ-038 ERROR holds error and goes to IDLE on the next cycle.
REQ-039 abort takes priority over every other event; the next state is IDLE.
REQ-040 If abort arrives in WRITE, mem_we drops on the next edge even when mem_ack arrives in the same cycle, and the write counts as not done.
REQ-041 start is ignored while busy.
REQ-042 in_valid outside ACCEPT has no effect.

Reset
REQ-043 While rst_n is low, all outputs are 0, the state is IDLE, and the address and count registers are 0.
REQ-044 Reset asserted mid-load discards the word in flight; mem_we drops immediately (asynchronously).

Verification
REQ-045 start with base_addr=0x0010, send add with A=1, B=2, dest=3, and mem_ack one cycle later -> mem_wdata=0x000A0003 at 0x0010 and word_count=1.
REQ-046 Send lw with A=0, B=1, offset=-1, then halt -> words 0x0081FFFF and 0x01800000 at consecutive addresses, and done pulses once.
REQ-047 Send sw with offset=40000 -> no mem_we, error=1, and IDLE the next cycle.
REQ-048 Hold mem_ack low for 5 cycles -> mem_we, mem_addr and mem_wdata stay constant, and in_ready stays 0.
REQ-049 base_addr=0xFFFF with a noop word acked -> error=1 and no further writes.
REQ-050 Drive rst_n low during WRITE -> mem_we=0 immediately, and busy=0 after release.
